cdc_toggle_event_rx: RTL and testbench
======================================

// Module: cdc_toggle_event_rx
// PURPOSE
// - Destination-side receiver for 8-lane toggle-encoded events sent from another clock domain.
// - Each lane's sender flips a level once per event.
// - Per lane, this block:
//   - synchronises the level into slow_clk;
//   - regenerates a one-cycle event pulse;
//   - returns the synchronised level as an ack toggle for the sender's handshake;
//   - keeps a saturating event counter readable by software.
// - Sits in the slow_clk domain, after the crossing from fast_clk.
// PARAMETERS
// - LANES        8   number of independent toggle lanes
// - SYNC_STAGES  2   synchroniser depth per lane; legal range 2..4
// - CNT_W        8   width of each lane's event counter
// PORTS
// - slow_clk       in   1                   destination clock
// - reset          in   1                   asynchronous, active-high reset
// - req_tgl_async  in   LANES               toggle levels from the sender domain (asynchronous)
// - ack_tgl        out  LANES               synchronised req levels, returned to the sender as ack
// - event_pulse    out  LANES               one-cycle pulse per received toggle
// - cnt_sel        in   $clog2(LANES)       lane selected for counter read/clear
// - cnt_clear      in   1                   clear counter and overflow of lane cnt_sel
// - cnt_value      out  CNT_W               registered count of lane cnt_sel
// - cnt_ovf        out  LANES               sticky per-lane saturation flags
// BEHAVIOUR
// - Reset: all sync flops, prev-level regs, counters, ack_tgl, event_pulse, cnt_value, cnt_ovf = 0.
//   - The sender must also reset its toggles to 0.
// - Synchroniser: plain SYNC_STAGES flop chain per lane; sync = last stage.
//   - ack_tgl = sync (no extra flop).
// - Edge detect: prev <= sync every cycle; event_pulse <= (sync ^ prev), registered.
// - Latency: E1 = first rising edge that samples a new req level.
//   - ack_tgl changes after edge E(SYNC_STAGES).
//   - event_pulse is high for exactly one cycle, after edge E(SYNC_STAGES+1).
// - Handshake rule: the sender may toggle a lane again only after it sees ack_tgl == req.
//   - Violations can lose events; the block does not detect them.
// - Warm-up: after reset release, a counter blocks pulses and counting for SYNC_STAGES+1 cycles.
//   - prev still tracks sync during warm-up.
//   - A lane whose req is already 1 at release therefore produces no spurious pulse.
// - Counter, per lane:
//   - +1 on each event_pulse.
//   - Saturates at 2^CNT_W-1; an event while saturated sets cnt_ovf[lane].
//   - Multiple lanes pulsing in the same cycle each count independently.
// - Clear: cnt_clear zeroes the counter and cnt_ovf of lane cnt_sel.
//   - Clear and event on the same lane in the same cycle: counter = 1, ovf = 0.
// - Read: cnt_value = count[cnt_sel] registered, one cycle of latency.
//   - Clear in cycle t: cnt_value shows the post-clear value at t+2.
// - Out-of-range cnt_sel (LANES not a power of 2): cnt_value = 0, clear ignored.
// - Reset mid-operation: immediate asynchronous clear of everything, then warm-up repeats.
// CONFIGURATION
// - CDC_RX_GLITCH_FILTER_EN defined:
//   - A lane's accepted level updates only when sync holds the same value for 2 consecutive cycles.
//   - ack_tgl and event_pulse each gain +1 cycle of latency.
//   - A sync level that reverts after 1 cycle produces no pulse and no ack change.
// - Not defined: no filter; latencies exactly as in BEHAVIOUR.
// TESTING (SYNC_STAGES=2, CNT_W=8)
// - T1 Reset release: req=8'h00 -> all outputs 0.
//   - With req=8'h05 held through reset: ack_tgl=8'h05 after 2 edges, no event_pulse ever.
// - T2 Single event: req[0] 0->1 before E1 -> ack_tgl[0]=1 after E2, event_pulse=8'h01 for one cycle after E3.
//   - cnt_sel=0 then gives cnt_value=1.
// - T3 Handshaked burst: lane 3 toggled 5 times, each after ack -> 5 single pulses.
//   - cnt_value=5 for cnt_sel=3; other lanes stay 0.
// - T4 Simultaneous lanes: req 8'h00->8'hFF in one cycle -> event_pulse=8'hFF once; each lane count=1.
// - T5 Saturation and clear: 257 events on lane 1 -> cnt_value=255, cnt_ovf[1]=1.
//   - cnt_clear with a same-cycle lane 1 event -> count=1, ovf=0.
// - T6 Mid-operation reset and filter:
//   - Reset asserted between E1 and E3 of a toggle -> no pulse, counts 0.
//   - With CDC_RX_GLITCH_FILTER_EN: a 1-cycle sync glitch gives no pulse.
//   - With CDC_RX_GLITCH_FILTER_EN: a clean toggle pulses after E4.

Source files
------------

// File: rtl/cdc_toggle_event_rx.sv
// cdc_toggle_event_rx
// Destination-side receiver for toggle-encoded events crossing into slow_clk.
// Per lane: synchroniser, one-cycle event pulse, ack toggle back to the sender
// and a saturating event counter with sticky overflow flag.
// Optional feature macro: CDC_RX_GLITCH_FILTER_EN
//   When defined, a lane's accepted level only moves once the synchronised level
//   is stable for two consecutive cycles (ack and pulse each one cycle later).
module cdc_toggle_event_rx #(
  parameter int LANES       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               slow_clk,
  input  logic               reset,
  input  logic [LANES-1:0]   req_tgl_async,
  output logic [LANES-1:0]   ack_tgl,
  output logic [LANES-1:0]   event_pulse,
  input  logic [SEL_W-1:0]   cnt_sel,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   cnt_value,
  output logic [LANES-1:0]   cnt_ovf
);

`ifdef CDC_RX_GLITCH_FILTER_EN
  localparam int WARM = SYNC_STAGES + 2;
`else
  localparam int WARM = SYNC_STAGES + 1;
`endif
  localparam int WARM_W = $clog2(WARM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LANES-1:0]  sync_q [SYNC_STAGES];
  logic [LANES-1:0]  sync_s;
  logic [LANES-1:0]  level_s;
  logic [LANES-1:0]  prev_q;
  logic [LANES-1:0]  pulse_q;
  logic [LANES-1:0]  pulse_d;
  logic [WARM_W-1:0] warm_q;
  logic [WARM_W-1:0] warm_d;
  logic              warm_done_s;
  logic [CNT_W-1:0]  cnt_q [LANES];
  logic [CNT_W-1:0]  cnt_d [LANES];
  logic [LANES-1:0]  ovf_q;
  logic [LANES-1:0]  ovf_d;
  logic [CNT_W-1:0]  cnt_value_q;
  logic [CNT_W-1:0]  cnt_value_d;

  // Plain flop chain per lane bringing the asynchronous toggles into slow_clk
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= req_tgl_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef CDC_RX_GLITCH_FILTER_EN
  logic [LANES-1:0] acc_q;
  logic [LANES-1:0] acc_d;
  logic [LANES-1:0] hold_s;

  // Accept a new level only when the stage behind sync already agrees with it,
  // i.e. sync will still hold this value in the next cycle
  always_comb begin
    hold_s = ~(sync_s ^ sync_q[SYNC_STAGES-2]);
    acc_d  = (acc_q & ~hold_s) | (sync_s & hold_s);
  end

  // Filtered accepted level register
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign level_s = acc_q;
`else
  assign level_s = sync_s;
`endif

  // The ack returned to the sender is the accepted level itself (already a flop)
  assign ack_tgl = level_s;

  // Warm-up counter: saturates once pulses may be trusted after reset release
  always_comb begin
    warm_done_s = (warm_q == WARM_W'(WARM));
    if (warm_done_s) begin
      warm_d = warm_q;
    end else begin
      warm_d = warm_q + WARM_W'(1);
    end
  end

  // Edge detector next state: a level change becomes a pulse once warmed up
  always_comb begin
    pulse_d = (level_s ^ prev_q) & {LANES{warm_done_s}};
  end

  // Previous level, registered pulse and warm-up state
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      pulse_q <= '0;
      warm_q  <= '0;
    end else begin
      prev_q  <= level_s;
      pulse_q <= pulse_d;
      warm_q  <= warm_d;
    end
  end

  assign event_pulse = pulse_q;

  // Per-lane counter next state: clear wins over overflow, a same-cycle event still counts
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cnt_d[l] = cnt_q[l];
      ovf_d[l] = ovf_q[l];
      if (cnt_clear && (int'(cnt_sel) == l)) begin
        cnt_d[l] = pulse_q[l] ? CNT_W'(1) : CNT_W'(0);
        ovf_d[l] = 1'b0;
      end else if (pulse_q[l]) begin
        if (cnt_q[l] == CNT_MAX) begin
          ovf_d[l] = 1'b1;
        end else begin
          cnt_d[l] = cnt_q[l] + CNT_W'(1);
        end
      end else begin
        cnt_d[l] = cnt_q[l];
      end
    end
  end

  // Read mux: out-of-range selections read as zero
  always_comb begin
    if (int'(cnt_sel) < LANES) begin
      cnt_value_d = cnt_q[cnt_sel];
    end else begin
      cnt_value_d = CNT_W'(0);
    end
  end

  // Counter, overflow and read-back registers
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        cnt_q[l] <= '0;
      end
      ovf_q       <= '0;
      cnt_value_q <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        cnt_q[l] <= cnt_d[l];
      end
      ovf_q       <= ovf_d;
      cnt_value_q <= cnt_value_d;
    end
  end

  assign cnt_value = cnt_value_q;
  assign cnt_ovf   = ovf_q;

endmodule

// File: tb/tb_cdc_toggle_event_rx.sv
// Scoreboard bench for cdc_toggle_event_rx (SYNC_STAGES=2, CNT_W=8).
// Stimulus pushes expected pulses (mask + cycle) into a queue; a monitor pops
// one entry every cycle the DUT shows a nonzero event_pulse.
module tb_cdc_toggle_event_rx;

  localparam int S = 2;
`ifdef CDC_RX_GLITCH_FILTER_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif
  localparam int LAT_ACK = S + F;
  localparam int LAT_P   = S + 1 + F;
  localparam int WARM    = S + 1 + F;

  typedef struct {
    logic [7:0] mask;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] ack_tgl;
  logic [7:0] event_pulse;
  logic [2:0] cnt_sel;
  logic       cnt_clear;
  logic [7:0] cnt_value;
  logic [7:0] cnt_ovf;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  cdc_toggle_event_rx #(.LANES(8), .SYNC_STAGES(S), .CNT_W(8)) dut (
    .slow_clk      (clk),
    .reset         (reset),
    .req_tgl_async (req),
    .ack_tgl       (ack_tgl),
    .event_pulse   (event_pulse),
    .cnt_sel       (cnt_sel),
    .cnt_clear     (cnt_clear),
    .cnt_value     (cnt_value),
    .cnt_ovf       (cnt_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with a pulse must match the oldest expected pulse
  always @(negedge clk) begin
    exp_t e;
    if (event_pulse !== 8'h00) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got=%h want=none", cyc, event_pulse);
      end else begin
        e = q.pop_front();
        if (event_pulse !== e.mask || cyc != e.cyc) begin
          fails++;
          $display("FAIL pulse got=%h@%0d want=%h@%0d", event_pulse, cyc, e.mask, e.cyc);
        end
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack_tgl !== req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check8("ack_handshake", ack_tgl, req);
  endtask

  task automatic toggle(input logic [7:0] mask);
    @(negedge clk);
    req = req ^ mask;
    q.push_back('{mask, cyc + LAT_P});
    wait_ack();
    repeat (3) @(negedge clk);
  endtask

  task automatic read_cnt(input string name, input logic [2:0] sel, input logic [7:0] want);
    @(negedge clk);
    cnt_sel = sel;
    @(negedge clk);
    check8(name, cnt_value, want);
  endtask

  task automatic do_reset(input logic [7:0] new_req);
    @(negedge clk);
    reset = 1'b1;
    req   = new_req;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (WARM + 3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = 8'h00;
    cnt_sel   = 3'd0;
    cnt_clear = 1'b0;

    // T1a: reset state with req=0
    repeat (3) @(negedge clk);
    check8("rst_ack", ack_tgl, 8'h00);
    check8("rst_pulse", event_pulse, 8'h00);
    check8("rst_cnt", cnt_value, 8'h00);
    check8("rst_ovf", cnt_ovf, 8'h00);
    reset = 1'b0;
    repeat (WARM + 3) @(negedge clk);
    check8("post_rst_ack", ack_tgl, 8'h00);

    // T2: single event on lane 0 with ack timing
    @(negedge clk);
    req[0] = 1'b1;
    q.push_back('{8'h01, cyc + LAT_P});
    repeat (LAT_ACK - 1) @(negedge clk);
    check8("t2_ack_early", ack_tgl, 8'h00);
    @(negedge clk);
    check8("t2_ack", ack_tgl, 8'h01);
    repeat (4) @(negedge clk);
    read_cnt("t2_cnt0", 3'd0, 8'd1);

    // T3: handshaked burst on lane 3
    for (int i = 0; i < 5; i++) toggle(8'h08);
    read_cnt("t3_cnt3", 3'd3, 8'd5);
    read_cnt("t3_cnt2", 3'd2, 8'd0);
    read_cnt("t3_cnt0", 3'd0, 8'd1);

    // T4: all lanes toggle 00 -> FF in one cycle
    do_reset(8'h00);
    read_cnt("t4_cnt3_after_rst", 3'd3, 8'd0);
    toggle(8'hFF);
    read_cnt("t4_cnt0", 3'd0, 8'd1);
    read_cnt("t4_cnt3", 3'd3, 8'd1);
    read_cnt("t4_cnt7", 3'd7, 8'd1);

    // T5: clear latency, saturation, clear with same-cycle event
    @(negedge clk);
    cnt_sel   = 3'd1;
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    check8("t5_clear_pre", cnt_value, 8'd1);
    @(negedge clk);
    check8("t5_clear_post", cnt_value, 8'd0);
    for (int i = 0; i < 255; i++) toggle(8'h02);
    read_cnt("t5_cnt255", 3'd1, 8'd255);
    check8("t5_ovf_not_yet", cnt_ovf, 8'h00);
    toggle(8'h02);
    toggle(8'h02);
    read_cnt("t5_cnt_sat", 3'd1, 8'd255);
    check8("t5_ovf_set", cnt_ovf, 8'h02);
    @(negedge clk);
    req = req ^ 8'h02;
    q.push_back('{8'h02, cyc + LAT_P});
    repeat (LAT_P) @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    check8("t5_clrev_pre", cnt_value, 8'd255);
    @(negedge clk);
    check8("t5_clrev_cnt", cnt_value, 8'd1);
    check8("t5_clrev_ovf", cnt_ovf, 8'h00);
    wait_ack();

    // T1b: req=05 held through reset -> ack after LAT_ACK edges, never a pulse
    @(negedge clk);
    reset = 1'b1;
    req   = 8'h05;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (LAT_ACK - 1) @(negedge clk);
    check8("t1b_ack_early", ack_tgl, 8'h00);
    @(negedge clk);
    check8("t1b_ack", ack_tgl, 8'h05);
    repeat (10) @(negedge clk);
    read_cnt("t1b_cnt0", 3'd0, 8'd0);

    // T6: reset between E1 and E3 of a lane 1 toggle
    @(negedge clk);
    req = req ^ 8'h02;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (WARM + 4) @(negedge clk);
    check8("t6_ack", ack_tgl, 8'h07);
    read_cnt("t6_cnt1", 3'd1, 8'd0);
    check8("t6_ovf", cnt_ovf, 8'h00);

`ifdef CDC_RX_GLITCH_FILTER_EN
    // T6 filter: one-cycle glitch on lane 4, then a clean toggle
    @(negedge clk);
    req = req ^ 8'h10;
    @(negedge clk);
    req = req ^ 8'h10;
    repeat (8) @(negedge clk);
    check8("t6_glitch_ack", ack_tgl, 8'h07);
    toggle(8'h10);
    read_cnt("t6_filter_cnt4", 3'd4, 8'd1);
`endif

    repeat (5) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses got=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
